dmem_arbiter: RTL and testbench

- Shares the single-port data memory (12-bit word address, 32-bit data, synchronous read) between two requesters: processor load/store (P) and a loader/debug port (L).
- Sits between the processor core and the dmem instance, in the same clock domain as dmem_clock.
- Issues at most one memory access per cycle. P has fixed priority, with a starvation guard for L.
- Returns read data with a one-cycle valid pulse to whichever requester issued the read.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between processor (P) and loader (L): one access/cycle, P priority with L starvation guard.
// Optional DMEM_ARB_STATS_EN adds saturating grant/conflict counters.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_q,
  input  logic              l_req,
  input  logic              l_wren,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_ready,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_q,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              starve_force
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_p_grants,
  output logic [15:0]       stat_l_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  typedef enum logic {PRI_P, PRI_L} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [3:0]        wcnt, wcnt_nxt;
  logic              gnt_p, gnt_l;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic              rpend, rsel;
  logic [DATA_W-1:0] p_q_hold, l_q_hold;

  always_comb begin
    state_nxt = PRI_P;
    wcnt_nxt  = 4'd0;
    gnt_p     = 1'b0;
    gnt_l     = 1'b0;
    case (state)
      PRI_P: begin
        gnt_p = p_req;
        gnt_l = !p_req && l_req;
        if (l_req && !gnt_l) wcnt_nxt = wcnt + 4'd1;
        if (wcnt_nxt == MAX_WAIT_C) state_nxt = PRI_L;
      end
      PRI_L: begin
        gnt_l = l_req;
        gnt_p = !l_req && p_req;
      end
      default: ;
    endcase
    // Nothing is accepted while reset is held.
    if (reset) begin
      gnt_p = 1'b0;
      gnt_l = 1'b0;
    end
  end

  assign p_ready      = gnt_p;
  assign l_ready      = gnt_l;
  assign starve_force = (state == PRI_L);

  // Idle cycles replay the last granted address/data with wren low.
  always_comb begin
    address_dmem = reset ? '0 : addr_hold;
    data         = reset ? '0 : data_hold;
    wren         = 1'b0;
    if (gnt_p) begin
      address_dmem = p_addr;
      data         = p_data;
      wren         = p_wren;
    end else if (gnt_l) begin
      address_dmem = l_addr;
      data         = l_data;
      wren         = l_wren;
    end
  end

  // Gating with reset kills a response for a load accepted just before reset.
  assign p_rvalid = rpend && !rsel && !reset;
  assign l_rvalid = rpend &&  rsel && !reset;
  assign p_q      = reset ? '0 : (p_rvalid ? q_dmem : p_q_hold);
  assign l_q      = reset ? '0 : (l_rvalid ? q_dmem : l_q_hold);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= PRI_P;
      wcnt      <= 4'd0;
      addr_hold <= '0;
      data_hold <= '0;
      rpend     <= 1'b0;
      rsel      <= 1'b0;
      p_q_hold  <= '0;
      l_q_hold  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (gnt_p || gnt_l) begin
        addr_hold <= address_dmem;
        data_hold <= data;
      end
      rpend <= (gnt_p && !p_wren) || (gnt_l && !l_wren);
      rsel  <= gnt_l;
      if (p_rvalid) p_q_hold <= q_dmem;
      if (l_rvalid) l_q_hold <= q_dmem;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_p_grants  <= 16'd0;
      stat_l_grants  <= 16'd0;
      stat_conflicts <= 16'd0;
    end else begin
      if (gnt_p && stat_p_grants != 16'hFFFF) stat_p_grants <= stat_p_grants + 16'd1;
      if (gnt_l && stat_l_grants != 16'hFFFF) stat_l_grants <= stat_l_grants + 16'd1;
      if (p_req && l_req && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read dmem model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p_req, p_wren;
  logic [11:0] p_addr;
  logic [31:0] p_data;
  logic        p_ready, p_rvalid;
  logic [31:0] p_q;
  logic        l_req, l_wren;
  logic [11:0] l_addr;
  logic [31:0] l_data;
  logic        l_ready, l_rvalid;
  logic [31:0] l_q;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        starve_force;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_p_grants, stat_l_grants, stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_ready(p_ready), .p_rvalid(p_rvalid), .p_q(p_q),
    .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
    .l_ready(l_ready), .l_rvalid(l_rvalid), .l_q(l_q),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
    .starve_force(starve_force)
`ifdef DMEM_ARB_STATS_EN
    , .stat_p_grants(stat_p_grants), .stat_l_grants(stat_l_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 2ns later.
  task automatic step(input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                      input logic lr, input logic lw, input logic [11:0] la, input logic [31:0] ld);
    @(negedge clock);
    p_req = pr; p_wren = pw; p_addr = pa; p_data = pd;
    l_req = lr; l_wren = lw; l_addr = la; l_data = ld;
    #2;
  endtask

  task automatic idle();
    step(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    reset = 1'b1;

    // Request held during reset must not be accepted.
    step(1, 1, 12'h055, 32'h11111111, 1, 0, 12'h066, 32'h0);
    step(1, 1, 12'h055, 32'h11111111, 1, 0, 12'h066, 32'h0);
    check("rst_p_ready", 32'(p_ready), 32'h0);
    check("rst_l_ready", 32'(l_ready), 32'h0);
    check("rst_p_rvalid", 32'(p_rvalid), 32'h0);
    check("rst_l_rvalid", 32'(l_rvalid), 32'h0);
    check("rst_p_q", p_q, 32'h0);
    check("rst_l_q", l_q, 32'h0);
    check("rst_wren", 32'(wren), 32'h0);
    check("rst_addr", 32'(address_dmem), 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_starve", 32'(starve_force), 32'h0);

    // P store then load.
    reset = 1'b0;
    step(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h0, 32'h0);
    check("pst_ready", 32'(p_ready), 32'h1);
    check("pst_wren", 32'(wren), 32'h1);
    check("pst_addr", 32'(address_dmem), 32'h010);
    check("pst_data", data, 32'hDEADBEEF);
    check("pst_l_ready", 32'(l_ready), 32'h0);
    step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0);
    check("pld_ready", 32'(p_ready), 32'h1);
    check("pld_wren", 32'(wren), 32'h0);
    idle();
    check("pld_rvalid", 32'(p_rvalid), 32'h1);
    check("pld_q", p_q, 32'hDEADBEEF);
    check("pld_l_rvalid", 32'(l_rvalid), 32'h0);
    check("idle_wren", 32'(wren), 32'h0);
    idle();
    check("pld_rvalid_pulse", 32'(p_rvalid), 32'h0);
    check("pld_q_hold", p_q, 32'hDEADBEEF);

    // L store then load.
    step(0, 0, 12'h0, 32'h0, 1, 1, 12'h020, 32'h12345678);
    check("lst_ready", 32'(l_ready), 32'h1);
    check("lst_wren", 32'(wren), 32'h1);
    check("lst_addr", 32'(address_dmem), 32'h020);
    step(0, 0, 12'h0, 32'h0, 1, 0, 12'h020, 32'h0);
    check("lld_ready", 32'(l_ready), 32'h1);
    check("lld_p_ready", 32'(p_ready), 32'h0);
    idle();
    check("lld_rvalid", 32'(l_rvalid), 32'h1);
    check("lld_q", l_q, 32'h12345678);
    check("lld_p_rvalid", 32'(p_rvalid), 32'h0);
    check("lld_p_q_hold", p_q, 32'hDEADBEEF);

    // Both requesting continuously: 4 P grants then 1 forced L grant.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 12'h000, 32'h0, 1, 0, 12'h001, 32'h0);
      check($sformatf("stv_p_ready_%0d", i), 32'(p_ready), (i % 5 == 4) ? 32'h0 : 32'h1);
      check($sformatf("stv_l_ready_%0d", i), 32'(l_ready), (i % 5 == 4) ? 32'h1 : 32'h0);
      check($sformatf("stv_force_%0d", i), 32'(starve_force), (i % 5 == 4) ? 32'h1 : 32'h0);
    end
    idle();
    check("stv_l_rvalid", 32'(l_rvalid), 32'h1);
    check("stv_l_q", l_q, 32'h2);

    // Back-to-back P loads of 0..3.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 12'(i), 32'h0, 0, 0, 12'h0, 32'h0);
      check($sformatf("b2b_ready_%0d", i), 32'(p_ready), 32'h1);
      check($sformatf("b2b_rvalid_%0d", i), 32'(p_rvalid), (i == 0) ? 32'h0 : 32'h1);
      if (i > 0) check($sformatf("b2b_q_%0d", i), p_q, 32'(i));
    end
    idle();
    check("b2b_rvalid_4", 32'(p_rvalid), 32'h1);
    check("b2b_q_4", p_q, 32'h4);

    // Load accepted, then reset: no response.
    step(1, 0, 12'h002, 32'h0, 0, 0, 12'h0, 32'h0);
    check("mrst_ready", 32'(p_ready), 32'h1);
    reset = 1'b1;
    idle();
    check("mrst_rvalid_in_reset", 32'(p_rvalid), 32'h0);
    check("mrst_p_q_in_reset", p_q, 32'h0);
    reset = 1'b0;
    idle();
    check("mrst_rvalid", 32'(p_rvalid), 32'h0);
    check("mrst_p_q", p_q, 32'h0);
    check("mrst_l_q", l_q, 32'h0);
    check("mrst_addr", 32'(address_dmem), 32'h0);
    check("mrst_data", data, 32'h0);
    check("mrst_wren", 32'(wren), 32'h0);
    check("mrst_starve", 32'(starve_force), 32'h0);
    step(1, 0, 12'h003, 32'h0, 1, 0, 12'h001, 32'h0);
    check("mrst_p_wins", 32'(p_ready), 32'h1);
    check("mrst_l_loses", 32'(l_ready), 32'h0);

    // Store to 0x3FF then 10 idle cycles: address/data hold, no writes.
    step(1, 1, 12'h3FF, 32'hA5A5A5A5, 0, 0, 12'h0, 32'h0);
    check("hold_st_wren", 32'(wren), 32'h1);
    for (int i = 0; i < 10; i++) begin
      idle();
      check($sformatf("hold_wren_%0d", i), 32'(wren), 32'h0);
      check($sformatf("hold_addr_%0d", i), 32'(address_dmem), 32'h3FF);
      check($sformatf("hold_data_%0d", i), data, 32'hA5A5A5A5);
    end
    check("hold_mem", mem[12'h3FF], 32'hA5A5A5A5);
`ifdef DMEM_ARB_STATS_EN
    check("stat_conflicts", 32'(stat_conflicts), 32'h1);
    check("stat_p_grants", 32'(stat_p_grants), 32'h2);
    check("stat_l_grants", 32'(stat_l_grants), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
